// File: rtl/mux2_arbiter_if.sv
// rtl/mux2_arbiter_if.sv - requester/mux-control bundle for mux2_arbiter
//
// Purpose: groups the requester handshake (req/gnt) and the mux-control
// outputs (sel/valid/busy) of mux2_arbiter into one bundle.
// Signals:
//   req   [1:0] requester i wants the mux, held until done
//   gnt   [1:0] one-hot-or-zero registered grant
//   sel         mux select (0 routes d0, 1 routes d1)
//   valid       high exactly when gnt != 0
//   busy        arbiter is settling or granting
// Modports:
//   master - requester side, drives req
//   slave  - arbiter side, drives gnt/sel/valid/busy
interface mux2_arbiter_if;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       sel;
  logic       valid;
  logic       busy;

  modport master (output req, input gnt, input sel, input valid, input busy);
  modport slave  (input req, output gnt, output sel, output valid, output busy);
endinterface

// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - round-robin owner of a shared 2:1 mux select line
//
// Purpose: arbitrates two requesters for one gate-level 2:1 mux, drives and
// holds the mux select, and waits a settle interval after each select
// change before granting so the mux output has propagated.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mux2_arbiter_if.slave (req in; gnt, sel, valid, busy out)
//   switch_count  [15:0] saturating count of select changes   (stats build)
//   preempt_count [7:0]  saturating count of hold preemptions (stats build)
// Optional feature: define MUX2_ARB_STATS_EN to add the two counters.
module mux2_arbiter #(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_HOLD      = 16,
  parameter int HOLD_W        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mux2_arbiter_if.slave bus
`ifdef MUX2_ARB_STATS_EN
  ,
  output logic [15:0]   switch_count,
  output logic [7:0]    preempt_count
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_GRANT  = 2'd2;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  // Loaded on entry to SETTLE; the grant edge is the one seen with count 1
  // (or 0), which makes req->gnt latency exactly SETTLE_CYCLES edges.
  localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

  logic [1:0]        state_q, state_d;
  logic              sel_q, sel_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              winner;
  logic              preempt;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    winner  = 1'b0;
    preempt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req != 2'b00) begin
          // Lone requester wins outright; on contention the one that did
          // not own the mux last time wins.
          winner = (bus.req == 2'b11) ? ~last_q : bus.req[1];
          sel_d  = winner;
          if ((winner != sel_q) && (SETTLE_CYCLES > 0)) begin
            state_d = ST_SETTLE;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_GRANT;
            gnt_d   = winner ? 2'b10 : 2'b01;
            hold_d  = '0;
          end
        end
      end
      ST_SETTLE: begin
        // The pending winner is whatever sel already points at.
        if (!bus.req[sel_q]) begin
          state_d = ST_IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_GRANT;
          gnt_d   = sel_q ? 2'b10 : 2'b01;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GRANT: begin
        // A simultaneous owner drop counts as a plain release, not a preemption.
        preempt = (MAX_HOLD > 0) && (hold_q == HOLD_LAST) &&
                  bus.req[~sel_q] && bus.req[sel_q];
        if (!bus.req[sel_q] || preempt) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
          last_d  = sel_q;
          hold_d  = '0;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.valid = |gnt_q;
  assign bus.busy  = (state_q != ST_IDLE);

`ifdef MUX2_ARB_STATS_EN
  logic [15:0] switch_count_q, switch_count_d;
  logic [7:0]  preempt_count_q, preempt_count_d;

  always_comb begin
    switch_count_d  = switch_count_q;
    preempt_count_d = preempt_count_q;
    if ((sel_d != sel_q) && (switch_count_q != 16'hFFFF)) begin
      switch_count_d = switch_count_q + 16'd1;
    end
    if (preempt && (preempt_count_q != 8'hFF)) begin
      preempt_count_d = preempt_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_count_q  <= 16'd0;
      preempt_count_q <= 8'd0;
    end else begin
      switch_count_q  <= switch_count_d;
      preempt_count_q <= preempt_count_d;
    end
  end

  assign switch_count  = switch_count_q;
  assign preempt_count = preempt_count_q;
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb/tb_mux2_arbiter.sv - self-checking bench for mux2_arbiter
module tb_mux2_arbiter;
  localparam int SC = 2;
  localparam int MH = 4;

  logic clk;
  logic rst_n;
  mux2_arbiter_if ifc ();

`ifdef MUX2_ARB_STATS_EN
  logic [15:0] switch_count;
  logic [7:0]  preempt_count;
`endif

  mux2_arbiter #(.SETTLE_CYCLES(SC), .MAX_HOLD(MH), .HOLD_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
`ifdef MUX2_ARB_STATS_EN
    ,
    .switch_count  (switch_count),
    .preempt_count (preempt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the mux, who is waiting for it and how many
  // edges of settling remain, plus the round-robin memory.
  int m_owner;   // -1 none
  int m_wait;    // -1 none
  int m_left;
  int m_sel;
  int m_last;
  int m_hold;
  int m_switch;
  int m_preempt;
  logic prev_valid;
  logic prev_sel;

  task automatic model_reset();
    m_owner = -1; m_wait = -1; m_left = 0; m_sel = 0; m_last = 1; m_hold = 0;
    m_switch = 0; m_preempt = 0; prev_valid = 1'b0; prev_sel = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] r);
    int w;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_hold = 0;
      end else if (MH > 0 && m_hold == MH - 1 && r[1 - m_owner]) begin
        if (m_preempt < 255) m_preempt++;
        m_last = m_owner; m_owner = -1; m_hold = 0;
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end else if (m_wait >= 0) begin
      if (!r[m_wait]) begin
        m_wait = -1;
      end else begin
        m_left--;
        if (m_left <= 0) begin
          m_owner = m_wait; m_wait = -1; m_hold = 0;
        end
      end
    end else if (r != 2'b00) begin
      if (r == 2'b11) w = 1 - m_last;
      else w = r[1] ? 1 : 0;
      if (w != m_sel) begin
        m_sel = w;
        if (m_switch < 65535) m_switch++;
        if (SC > 0) begin
          m_wait = w; m_left = SC - 1;
          if (m_left <= 0) begin m_owner = w; m_wait = -1; m_hold = 0; end
        end else begin
          m_owner = w; m_hold = 0;
        end
      end else begin
        m_owner = w; m_hold = 0;
      end
    end
  endtask

  task automatic compare();
    logic [1:0] eg;
    eg = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
    check("gnt", ifc.gnt, eg);
    check("sel", ifc.sel, m_sel);
    check("valid", ifc.valid, eg != 2'b00);
    check("busy", ifc.busy, (m_owner >= 0) || (m_wait >= 0));
    check("gnt_not_both", ifc.gnt == 2'b11, 1'b0);
    if (prev_valid && ifc.valid) check("sel_stable", ifc.sel, prev_sel);
`ifdef MUX2_ARB_STATS_EN
    check("switch_count", switch_count, m_switch);
    check("preempt_count", preempt_count, m_preempt);
`endif
    prev_valid = ifc.valid;
    prev_sel   = ifc.sel;
  endtask

  task automatic step();
    logic [1:0] r;
    r = ifc.req;
    @(posedge clk);
    model_edge(r);
    #1;
    compare();
  endtask

  task automatic do_reset();
    ifc.req = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("rst_gnt", ifc.gnt, 2'b00);
    check("rst_sel", ifc.sel, 1'b0);
    check("rst_valid", ifc.valid, 1'b0);
    check("rst_busy", ifc.busy, 1'b0);
  endtask

  initial begin
    logic [1:0] r;
    ifc.req = 2'b00;
    rst_n = 1'b0;
    model_reset();

    // Lone requester 0: immediate grant, 1-cycle release.
    do_reset();
    ifc.req = 2'b01;
    step();
    check("t1_gnt", ifc.gnt, 2'b01);
    check("t1_valid", ifc.valid, 1'b1);
    check("t1_sel", ifc.sel, 1'b0);
    repeat (3) step();
    ifc.req = 2'b00;
    step();
    check("t1_release", ifc.gnt, 2'b00);

    // Lone requester 1: select change costs SC edges.
    do_reset();
    ifc.req = 2'b10;
    step();
    check("t2_sel", ifc.sel, 1'b1);
    check("t2_busy", ifc.busy, 1'b1);
    check("t2_gnt_wait", ifc.gnt, 2'b00);
    step();
    check("t2_gnt", ifc.gnt, 2'b10);

    // Continuous contention: alternating, preempted grants.
    do_reset();
    ifc.req = 2'b11;
    repeat (30) step();

    // Drop during settle, then quick re-grant on unchanged sel.
    do_reset();
    ifc.req = 2'b10;
    step();
    ifc.req = 2'b00;
    step();
    check("t4_no_gnt", ifc.gnt, 2'b00);
    check("t4_idle", ifc.busy, 1'b0);
    check("t4_sel", ifc.sel, 1'b1);
    ifc.req = 2'b10;
    step();
    check("t4_regrant", ifc.gnt, 2'b10);

    // Asynchronous reset while requester 1 owns the mux.
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_gnt", ifc.gnt, 2'b00);
    check("t5_async_valid", ifc.valid, 1'b0);
    check("t5_async_sel", ifc.sel, 1'b0);
    check("t5_async_busy", ifc.busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ifc.req = 2'b11;
    step();
    check("t5_first_winner", ifc.gnt, 2'b01);

`ifdef MUX2_ARB_STATS_EN
    // Grants 0 -> 1 -> 0 give two select changes, then one preemption.
    do_reset();
    ifc.req = 2'b01; step();
    ifc.req = 2'b00; step();
    ifc.req = 2'b10; step(); step();
    ifc.req = 2'b00; step();
    ifc.req = 2'b01; step(); step();
    check("stats_switch2", switch_count, 16'd2);
    ifc.req = 2'b11;
    repeat (MH) step();
    check("stats_preempt1", preempt_count, 8'd1);
`endif

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = ifc.req;
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 9) < 2) r[b] = ~r[b];
      end
      ifc.req = r;
      step();
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rand_async_gnt", ifc.gnt, 2'b00);
        check("rand_async_sel", ifc.sel, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Clocked round-robin controller that shares one gate-level 2->1 multiplexer (d0/d1/sel -> z) between two requesters.
- Drives the mux select line and holds it stable.
- Inserts a programmable settle interval after every select change so the mux propagation delay has elapsed before a grant is given.
- Sits directly above the mux instance; the requesters see only req/gnt.

Parameters:
- SETTLE_CYCLES, 2, cycles waited after sel changes before a grant is issued; 0 means no wait.
- MAX_HOLD, 16, maximum consecutive grant cycles while the other requester waits; 0 disables preemption.
- HOLD_W, 8, width of the internal hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  2  req[i] high = requester i wants the mux; held until done.
- gnt  output  2  one-hot-or-zero grant, registered.
- sel  output  1  mux select, registered; 0 routes d0, 1 routes d1.
- valid  output  1  high exactly when gnt != 0; mux output is settled and owned.
- busy  output  1  high in SETTLE or GRANT.

Behaviour:
- Reset (async assert, sync release): state=IDLE, sel=0, gnt=0, valid=0, busy=0, last=1 (requester 0 wins first), hold=0, settle counter=0.
- States: IDLE, SETTLE, GRANT.
- IDLE, on an edge where req != 0:
  - Winner: the single active requester; if both are active, the one != last.
  - sel <= winner.
  - If sel changes and SETTLE_CYCLES > 0: go to SETTLE with counter = SETTLE_CYCLES-1.
  - Otherwise: go to GRANT, with gnt[winner]=1 and valid=1 registered at this same edge (1-cycle latency from req).
- SETTLE:
  - Counter decrements each edge; at counter==0, go to GRANT and assert gnt.
  - Total latency from req to gnt is SETTLE_CYCLES edges.
  - If req[winner] drops during SETTLE: return to IDLE with no grant; sel keeps its new value; last is unchanged.
- GRANT:
  - sel, gnt and valid are constant.
  - hold increments each edge, saturating at 2^HOLD_W-1.
  - If req[owner] is low at an edge: gnt <= 0, valid <= 0, last <= owner, hold <= 0, go to IDLE. This is a 1-cycle release latency.
  - Preemption: MAX_HOLD > 0, hold == MAX_HOLD-1 and req[other] high. Then gnt <= 0, last <= owner, go to IDLE; the other requester wins on the next edge.
  - Owner drop and preemption on the same edge: treated as a normal release; results are identical.
- sel never changes while valid=1. gnt is never 2'b11.
- A requester may re-request immediately after release. If it is the only requester, it is re-granted with no settle, because sel is unchanged.
- Reset asserted mid-SETTLE or mid-GRANT drops gnt/valid/busy immediately (asynchronously); sel returns to 0.
- Round-robin fairness: with both requesters continuously active, grants alternate 0,1,0,1...

Optional Feature:
- Macro: MUX2_ARB_STATS_EN.
- Defined:
  - Adds output switch_count (16 bits).
  - Resets to 0.
  - Increments by 1 on every edge where sel changes value; saturates at 16'hFFFF.
  - Also adds output preempt_count (8 bits, saturating), incremented on each preemption.
- Not defined: neither port nor its counter exists; all other behaviour is identical.

Test Plan:
- Reset, then req=2'b01 at edge 1 -> sel stays 0, gnt=2'b01 and valid=1 after edge 1; drop req at edge 5 -> gnt=0 after edge 5.
- Reset, then req=2'b10 with SETTLE_CYCLES=2 -> sel=1 after edge 1, busy=1, gnt=0 after edge 1, gnt=2'b10 after edge 2.
- req=2'b11 held continuously, MAX_HOLD=4, SETTLE_CYCLES=2:
  - gnt sequence is 01 for 4 cycles, 00 during IDLE+settle, then 10 for 4 cycles, repeating.
  - sel is constant whenever valid=1.
- req=2'b10 asserted, then dropped during SETTLE -> gnt never asserts, state returns to IDLE, sel=1; a following req=2'b10 is granted with 1-cycle latency.
- rst_n pulled low mid-GRANT (gnt=2'b10) -> gnt=0, valid=0, sel=0 immediately without a clock edge; after release, req=2'b11 grants requester 0 first.
- With MUX2_ARB_STATS_EN: three alternating grants 0->1->0 -> switch_count=2; forced preemption -> preempt_count increments by 1.
